vga_fb_writer: RTL

AXI4 write master that fills the DDR framebuffer the VGA scan-out engine reads. A producer hands it a write command (start address and beat count), then streams 128-bit pixel words. The block splits the command into INCR bursts that never cross a 4 KB boundary or exceed `MAX_BURST` beats, and reports completion and write errors. It sits on `mem_clk` beside the display read master, sharing the DDR interconnect.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_fb_writer_if.sv | 71 +++++++
 rtl/vga_fb_writer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer AXI masters: response/burst encodings,
// the writer FSM state type and the 4 KB-safe burst length helper.
package vga_pkg;

    localparam logic [1:0] AXI4_OKAY      = 2'b00;
    localparam logic [1:0] AXI4_SLVERR    = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;

    typedef enum logic [1:0] {
        FB_IDLE = 2'd0,
        FB_AW   = 2'd1,
        FB_W    = 2'd2,
        FB_B    = 2'd3
    } fb_wr_cs_t;

    // Beats for the next burst: limited by what is left, the burst cap and the
    // distance to the next 4 KB page. addr[3:0] is assumed zero.
    function automatic logic [8:0] fb_burst_len(input logic [26:0] addr,
                                                input logic [8:0]  remaining,
                                                input logic [8:0]  max_burst);
        logic [12:0] beats_4k;
        logic [8:0]  len;
        beats_4k = (13'd4096 - {1'b0, addr[11:0]}) >> 4;
        len = remaining;
        if (len > max_burst) len = max_burst;
        if ({4'd0, len} > beats_4k) len = beats_4k[8:0];
        return len;
    endfunction

endpackage

// File: rtl/vga_fb_writer_if.sv
// Command, pixel-stream and AXI4 write-channel bundle of the framebuffer writer.
// Every channel transfers on a rising edge where its valid and ready are both high;
// a raised valid and its payload stay put until that transfer happens.
interface vga_fb_writer_if;
    import vga_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [26:0]  cmd_addr;
    logic [8:0]   cmd_words;

    logic         pix_valid;
    logic         pix_ready;
    logic [127:0] pix_data;

    logic [3:0]   mem_awid;
    logic [26:0]  mem_awaddr;
    logic [7:0]   mem_awlen;
    logic [2:0]   mem_awsize;
    logic [1:0]   mem_awburst;
    logic         mem_awlock;
    logic         mem_awvalid;
    logic         mem_awready;

    logic [127:0] mem_wdata;
    logic [15:0]  mem_wstrb;
    logic         mem_wlast;
    logic         mem_wvalid;
    logic         mem_wready;

    logic [3:0]   mem_bid;
    logic [1:0]   mem_bresp;
    logic         mem_bvalid;
    logic         mem_bready;

    logic         busy;
    logic         done;
    logic         err;
    logic         err_clear;

    fb_wr_cs_t    state;

    modport master (
        input  cmd_valid, cmd_addr, cmd_words,
        input  pix_valid, pix_data,
        input  mem_awready, mem_wready,
        input  mem_bid, mem_bresp, mem_bvalid,
        input  err_clear,
        output cmd_ready, pix_ready,
        output mem_awid, mem_awaddr, mem_awlen, mem_awsize, mem_awburst,
        output mem_awlock, mem_awvalid,
        output mem_wdata, mem_wstrb, mem_wlast, mem_wvalid,
        output mem_bready,
        output busy, done, err, state
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_words,
        output pix_valid, pix_data,
        output mem_awready, mem_wready,
        output mem_bid, mem_bresp, mem_bvalid,
        output err_clear,
        input  cmd_ready, pix_ready,
        input  mem_awid, mem_awaddr, mem_awlen, mem_awsize, mem_awburst,
        input  mem_awlock, mem_awvalid,
        input  mem_wdata, mem_wstrb, mem_wlast, mem_wvalid,
        input  mem_bready,
        input  busy, done, err, state
    );

endinterface

// File: rtl/vga_fb_writer.sv
// AXI4 write master filling the DDR framebuffer: splits each command into INCR
// bursts that respect MAX_BURST and 4 KB pages, one burst outstanding at a time.
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'h1
) (
    input  logic            mem_clk,
    input  logic            mem_reset,
    vga_fb_writer_if.master bus
);

    localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);

    fb_wr_cs_t   state, state_d;
    logic [26:0] addr, addr_d;
    logic [8:0]  remaining, remaining_d;
    logic [8:0]  beat_cnt, beat_cnt_d;
    logic [8:0]  burst_len, len_d;
    logic        done_d, err_set;
    logic        cmd_acc, aw_hs, w_hs, b_hs;

    assign cmd_acc = bus.cmd_valid & bus.cmd_ready;
    assign aw_hs   = bus.mem_awvalid & bus.mem_awready;
    assign w_hs    = (state == FB_W) & bus.pix_valid & bus.mem_wready;
    assign b_hs    = bus.mem_bvalid & bus.mem_bready;

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        remaining_d = remaining;
        beat_cnt_d  = beat_cnt;
        done_d      = 1'b0;
        err_set     = 1'b0;
        case (state)
            FB_IDLE: begin
                if (cmd_acc) begin
                    addr_d      = bus.cmd_addr & ~27'hF;
                    remaining_d = bus.cmd_words;
                    if (bus.cmd_words == 9'd0) done_d = 1'b1;
                    else                       state_d = FB_AW;
                end
            end
            FB_AW: begin
                if (aw_hs) begin
                    addr_d      = addr + {14'd0, burst_len, 4'h0};
                    remaining_d = remaining - burst_len;
                    beat_cnt_d  = burst_len;
                    state_d     = FB_W;
                end
            end
            FB_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt - 9'd1;
                    if (beat_cnt == 9'd1) state_d = FB_B;
                end
            end
            FB_B: begin
                if (b_hs) begin
                    err_set = (bus.mem_bresp != AXI4_OKAY);
                    if (remaining == 9'd0) begin
                        done_d  = 1'b1;
                        state_d = FB_IDLE;
                    end else begin
                        state_d = FB_AW;
                    end
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // Burst length is computed from the values the AW state will see on entry,
    // so the AW fields come straight out of flops.
    assign len_d = fb_burst_len(addr_d, remaining_d, MAX_BURST_W);

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state           <= FB_IDLE;
            addr            <= '0;
            remaining       <= '0;
            beat_cnt        <= '0;
            burst_len       <= '0;
            bus.cmd_ready   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.mem_awvalid <= 1'b0;
            bus.mem_awaddr  <= '0;
            bus.mem_awlen   <= '0;
            bus.mem_bready  <= 1'b0;
        end else begin
            state           <= state_d;
            addr            <= addr_d;
            remaining       <= remaining_d;
            beat_cnt        <= beat_cnt_d;
            bus.cmd_ready   <= (state_d == FB_IDLE) && !done_d;
            bus.busy        <= (state_d != FB_IDLE) || done_d;
            bus.done        <= done_d;
            bus.mem_awvalid <= (state_d == FB_AW);
            bus.mem_bready  <= (state_d == FB_B);
            if (state_d == FB_AW && state != FB_AW) begin
                bus.mem_awaddr <= addr_d;
                bus.mem_awlen  <= 8'(len_d - 9'd1);
                burst_len      <= len_d;
            end
            // A fresh error beats a simultaneous clear.
            if (err_set)            bus.err <= 1'b1;
            else if (bus.err_clear) bus.err <= 1'b0;
        end
    end

    assign bus.mem_wvalid  = (state == FB_W) & bus.pix_valid;
    assign bus.pix_ready   = (state == FB_W) & bus.mem_wready;
    assign bus.mem_wdata   = bus.pix_data;
    assign bus.mem_wstrb   = (state == FB_W) ? 16'hFFFF : 16'h0000;
    assign bus.mem_wlast   = (state == FB_W) && (beat_cnt == 9'd1);

    assign bus.mem_awid    = AXI_ID;
    assign bus.mem_awsize  = AXI_SIZE_16B;
    assign bus.mem_awburst = AXI_BURST_INCR;
    assign bus.mem_awlock  = 1'b0;

    assign bus.state       = state;

endmodule
